// File: rtl/reg_writeback_pkg.sv
// Shared constants for the write-back commit unit and a one-hot helper.
package reg_writeback_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 32;
    localparam int REG_W      = 5;
    localparam int DEPTH_DEF  = 4;

    // One-hot encoding of a register index into a 32-bit mask.
    function automatic logic [31:0] rd_onehot(input logic [REG_W-1:0] rd);
        return 32'd1 << rd;
    endfunction

endpackage

// File: rtl/reg_writeback_fifo.sv
// Two-write, one-read synchronous FIFO for committed results.
// Port 0 is the older result and lands first when both ports write together.
// The head pops automatically whenever the FIFO holds at least one entry.
module wb_fifo
    import reg_writeback_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int DW    = DATA_W_DEF,
    parameter int AW    = ADDR_W_DEF,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr0_en,
    input  logic [REG_W-1:0]           wr0_rd,
    input  logic [DW-1:0]              wr0_data,
    input  logic [AW-1:0]              wr0_pc,
    input  logic                       wr1_en,
    input  logic [REG_W-1:0]           wr1_rd,
    input  logic [DW-1:0]              wr1_data,
    input  logic [AW-1:0]              wr1_pc,
    output logic                       empty,
    output logic [REG_W-1:0]           head_rd,
    output logic [DW-1:0]              head_data,
    output logic [AW-1:0]              head_pc,
    output logic [CW-1:0]              free,
    output logic [DEPTH-1:0]           ent_valid,
    output logic [DEPTH-1:0][REG_W-1:0] ent_rd
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [REG_W-1:0] mem_rd   [DEPTH];
    logic [DW-1:0]    mem_data [DEPTH];
    logic [AW-1:0]    mem_pc   [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [PW-1:0] wr1_idx;
    logic          pop;

    assign empty     = (count == '0);
    assign pop       = !empty;
    assign free      = DEPTH_C - count;
    assign wr1_idx   = wr0_en ? (wr_ptr + PW'(1)) : wr_ptr;
    assign head_rd   = mem_rd[rd_ptr];
    assign head_data = mem_data[rd_ptr];
    assign head_pc   = mem_pc[rd_ptr];

    // Pointer and occupancy bookkeeping; pushes never exceed the free count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(wr0_en) + PW'(wr1_en);
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + CW'(wr0_en) + CW'(wr1_en) - CW'(pop);
        end
    end

    // Entry storage; stale slots are masked by ent_valid so no reset needed.
    always_ff @(posedge clk) begin
        if (wr0_en) begin
            mem_rd[wr_ptr]   <= wr0_rd;
            mem_data[wr_ptr] <= wr0_data;
            mem_pc[wr_ptr]   <= wr0_pc;
        end
        if (wr1_en) begin
            mem_rd[wr1_idx]   <= wr1_rd;
            mem_data[wr1_idx] <= wr1_data;
            mem_pc[wr1_idx]   <= wr1_pc;
        end
    end

    // A slot is live when its distance from the read pointer is below count.
    always_comb begin
        logic [PW-1:0] offs;
        offs      = '0;
        ent_valid = '0;
        ent_rd    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs         = PW'(i) - rd_ptr;
            ent_valid[i] = ({1'b0, offs} < count);
            ent_rd[i]    = mem_rd[i];
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// Write-back commit unit: merges ALU and load results into the single
// register-file write port, one commit per cycle, with a hazard mask.
module reg_writeback
    import reg_writeback_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int DW    = DATA_W_DEF,
    parameter int AW    = ADDR_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [REG_W-1:0] alu_rd,
    input  logic [DW-1:0]    alu_data,
    input  logic [AW-1:0]    alu_pc,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [REG_W-1:0] ld_rd,
    input  logic [DW-1:0]    ld_data,
    input  logic [AW-1:0]    ld_pc,
    output logic             wb_en,
    output logic [REG_W-1:0] wb_num,
    output logic [DW-1:0]    wb_data,
    output logic [AW-1:0]    wb_pc,
    output logic [31:0]      pend_mask,
    output logic [31:0]      retired
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]                 free;
    logic                          empty;
    logic [REG_W-1:0]              head_rd;
    logic [DW-1:0]                 head_data;
    logic [AW-1:0]                 head_pc;
    logic [DEPTH-1:0]              ent_valid;
    logic [DEPTH-1:0][REG_W-1:0]   ent_rd;
    logic                          ld_push;
    logic                          alu_push;
    logic [31:0]                   retired_cnt;

    // Load has priority for the last free slot since it is the older result.
    assign ld_ready  = (free >= CW'(1));
    assign alu_ready = (free >= CW'(2)) || ((free == CW'(1)) && !ld_valid);

    // x0 writes complete the handshake but never occupy a slot.
    assign ld_push  = ld_valid  && ld_ready  && (ld_rd  != '0);
    assign alu_push = alu_valid && alu_ready && (alu_rd != '0);

    wb_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .AW    (AW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr0_en    (ld_push),
        .wr0_rd    (ld_rd),
        .wr0_data  (ld_data),
        .wr0_pc    (ld_pc),
        .wr1_en    (alu_push),
        .wr1_rd    (alu_rd),
        .wr1_data  (alu_data),
        .wr1_pc    (alu_pc),
        .empty     (empty),
        .head_rd   (head_rd),
        .head_data (head_data),
        .head_pc   (head_pc),
        .free      (free),
        .ent_valid (ent_valid),
        .ent_rd    (ent_rd)
    );

    // Output stage: load the FIFO head every cycle it is non-empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_en   <= 1'b0;
            wb_num  <= '0;
            wb_data <= '0;
            wb_pc   <= '0;
        end else begin
            wb_en <= !empty;
            if (!empty) begin
                wb_num  <= head_rd;
                wb_data <= head_data;
                wb_pc   <= head_pc;
            end
        end
    end

    // Retired-write counter, free-running modulo 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            retired_cnt <= '0;
        end else if (!empty) begin
            retired_cnt <= retired_cnt + 32'd1;
        end
    end

    assign retired = retired_cnt;

    // Pending mask covers queued entries plus the entry in the output stage.
    always_comb begin
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i]) begin
                m = m | rd_onehot(ent_rd[i]);
            end
        end
        if (wb_en) begin
            m = m | rd_onehot(wb_num);
        end
        m[0]      = 1'b0;
        pend_mask = m;
    end

endmodule

// File: doc/reg_writeback.md
# reg_writeback

Write-back commit unit that sits in front of the register file's single write port. It accepts results from the ALU path and the load path, orders them through a small FIFO, and drives exactly one register write per cycle. It also exports a pending-destination mask for decode-stage hazard checks and a retired-write counter.

## Interface
- DEPTH, 4, FIFO entries; power of two, at least 2.
- DW, 32, data width; takes the shared data-width constant.
- AW, 32, PC width; takes the shared address-width constant.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- alu_valid  in  1  ALU result offered.
- alu_ready  out  1  ALU result accepted this cycle if alu_valid is high.
- alu_rd  in  5  ALU destination register.
- alu_data  in  DW  ALU result.
- alu_pc  in  AW  PC of the producing instruction.
- ld_valid  in  1  load result offered.
- ld_ready  out  1  load result accepted this cycle if ld_valid is high.
- ld_rd  in  5  load destination register.
- ld_data  in  DW  load result.
- ld_pc  in  AW  PC of the load.
- wb_en  out  1  register write enable.
- wb_num  out  5  register index to write.
- wb_data  out  DW  write data.
- wb_pc  out  AW  PC of the committed instruction, used for the commit trace.
- pend_mask  out  32  bit r is set while any queued or output-stage entry targets register r; bit 0 is always 0.
- retired  out  32  count of wb_en cycles.

## Operation
- Handshake: a transfer occurs when valid and ready are both high in the same cycle. Ready is computed combinationally from the FIFO free count `free`:
  - ld_ready = (free ≥ 1).
  - alu_ready = (free ≥ 2) or (free == 1 and not ld_valid).
- Ordering: when both ports transfer in the same cycle, the load entry is enqueued first because it belongs to the older instruction. The ALU entry follows it.
- Results with rd == 0 are handshaken normally but are not enqueued, and they consume no FIFO space.
  - The ready computation still uses the true free count, so ready never depends on rd.
- Pop: whenever the FIFO is non-empty at a rising edge, the head entry moves into the output registers (wb_en=1, wb_num, wb_data, wb_pc). If the FIFO is empty, wb_en=0 and the other outputs hold their last values.
- Enqueue and pop in the same edge are both permitted. The count update is count + pushes − pop.
  - `free` is computed from the pre-edge count only. A slot freed by this edge's pop is not reusable until the next cycle.
- retired increments by 1 on each edge where wb_en is driven high for the following cycle. It wraps from 0xFFFF_FFFF to 0.
- pend_mask is the combinational OR of one-hot(rd) over the valid FIFO entries, plus wb_num when wb_en=1.
- Reset values: FIFO empty, alu_ready=ld_ready=1 (both depend on free=DEPTH), wb_en=0, wb_num=0, wb_data=0, wb_pc=0, pend_mask=0, retired=0.
- Reset mid-operation: all queued entries are discarded and input handshakes during the reset cycle are ignored.

## Timing
- Latency from an accepted input (edge E0) to wb_en is one edge: the entry is written at E0 and popped into the output registers at E1.
  - Consequently, with an empty FIFO an input offered in cycle N produces wb_en high during cycle N+2.
- Throughput is one commit per cycle. A sustained two-per-cycle input rate backpressures the ALU port first.
- Output registers change only on the rising edge. The register file samples wb_* on the falling edge, so the values are stable for a full half-cycle before sampling.
- Full condition: free == 0 drives both readies low. Empty condition: wb_en goes low on the next edge.
- FIFO pointers wrap modulo DEPTH. The count has width log2(DEPTH)+1.

## Structure
- The shared defines file provides the data-width, address-width and register-number-width constants. No new package content is required beyond a DEPTH default constant.
- One sub-module, `wb_fifo`, is the natural split:
  - a two-write, one-read synchronous FIFO;
  - exposes free count and per-entry valid/rd for building pend_mask.
- The top level holds the ready logic, the output registers and the retired counter.

## Test plan
- Single ALU write: after reset, send alu rd=5, data=0x1234, pc=0x100 → wb_en=1, wb_num=5, wb_data=0x1234, wb_pc=0x100 two cycles later, retired=1, and pend_mask bit 5 is set from the accept edge until wb_en drops.
- Simultaneous inputs: ld rd=3/0xAA and alu rd=4/0xBB in the same cycle, FIFO empty → commits occur in order x3=0xAA then x4=0xBB on consecutive cycles.
- x0 discard: alu rd=0 data=0xFFFF → handshake completes, no wb_en pulse, retired unchanged, pend_mask=0.
- Backpressure: hold both ports valid continuously with distinct rd values → with DEPTH=4, alu_ready drops while ld_ready stays high at free=1. No entry is lost or duplicated, verified against a scoreboard.
- Reset mid-flight: fill the FIFO with 4 entries, then assert reset for 1 cycle → after reset no wb_en pulses, pend_mask=0, retired=0, both readies high.
- Counter wrap: force retired to 0xFFFF_FFFF via a hierarchical deposit, commit one write → retired=0.
